// File: rtl/unpool2x2.sv
// 2x2 nearest-neighbour unpooling: each pooled word is emitted twice and each row is replayed once.
// Optional frame marker out_eof and its row counter are compiled in with `define UNPOOL_EOF_EN.
module unpool2x2 #(
    parameter int WORD_SIZE = 16,
    parameter int IN_WIDTH  = 14,
    parameter int IN_HEIGHT = 14
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [WORD_SIZE-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [WORD_SIZE-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready
`ifdef UNPOOL_EOF_EN
    ,
    output logic                        out_eof
`endif
);

    localparam int COL_W = $clog2(IN_WIDTH);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_WIDTH - 1);

    // The state names where the next word loaded into the output register comes from.
    typedef enum logic {
        FILL   = 1'b0,
        REPLAY = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic [COL_W-1:0]             col_q, col_d;
    logic                         dup_q, dup_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [WORD_SIZE-1:0]  out_data_q, out_data_d;
    logic signed [WORD_SIZE-1:0]  row_buf [IN_WIDTH];

    logic transfer;
    logic slot_free;
    logic fill_load;
    logic load;
    logic col_wrap;

    always_comb begin
        transfer  = out_valid_q && out_ready;
        slot_free = !out_valid_q || (out_ready && !dup_q);
        in_ready  = (state_q == FILL) && slot_free && !reset;
        fill_load = in_ready && in_valid;
        load      = fill_load || ((state_q == REPLAY) && slot_free);
        col_wrap  = (col_q == COL_LAST);

        state_d     = state_q;
        col_d       = col_q;
        dup_d       = dup_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (load) begin
            out_data_d  = (state_q == FILL) ? in_data : row_buf[col_q];
            out_valid_d = 1'b1;
            dup_d       = 1'b1;
            if (col_wrap) begin
                col_d   = '0;
                state_d = (state_q == FILL) ? REPLAY : FILL;
            end else begin
                col_d = col_q + 1'b1;
            end
        end else if (transfer) begin
            // First copy leaves: keep the word for its second copy; second copy leaves: slot empties.
            if (dup_q) begin
                dup_d = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FILL;
            col_q       <= '0;
            dup_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            dup_q       <= dup_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Row store is never reset: every entry is rewritten in FILL before REPLAY reads it.
    always_ff @(posedge clk) begin
        if (fill_load) begin
            row_buf[col_q] <= in_data;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

`ifdef UNPOOL_EOF_EN
    localparam int ROW_W = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_HEIGHT - 1);

    logic [ROW_W-1:0] row_q, row_d;
    logic             last_q, last_d;
    logic             eof_q, eof_d;

    // last_q marks that the held word is the final replayed word of the frame; eof rises on its second copy.
    always_comb begin
        row_d  = row_q;
        last_d = last_q;
        eof_d  = eof_q;
        if (load) begin
            last_d = (state_q == REPLAY) && col_wrap && (row_q == ROW_LAST);
            eof_d  = 1'b0;
            if ((state_q == REPLAY) && col_wrap) begin
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end
        end else if (transfer) begin
            eof_d = dup_q ? last_q : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q  <= '0;
            last_q <= 1'b0;
            eof_q  <= 1'b0;
        end else begin
            row_q  <= row_d;
            last_q <= last_d;
            eof_q  <= eof_d;
        end
    end

    assign out_eof = eof_q;
`endif

endmodule

// File: tb/tb_unpool2x2.sv
// Self-checking bench for unpool2x2: directed vector table, reset/hold sequences and a randomized run.
// Runs with IN_WIDTH=2, IN_HEIGHT=2; out_eof is checked when UNPOOL_EOF_EN is defined.
module tb_unpool2x2;

    localparam int W  = 16;
    localparam int IW = 2;
    localparam int IH = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
`ifdef UNPOOL_EOF_EN
    logic         out_eof;
`endif

    unpool2x2 #(
        .WORD_SIZE (W),
        .IN_WIDTH  (IW),
        .IN_HEIGHT (IH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef UNPOOL_EOF_EN
        ,
        .out_eof   (out_eof)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int              n_in;
        logic [0:3][15:0]  vin;
        bit              toggle;
        int              n_out;
        logic [0:15][15:0] vout;
    } vec_t;

    int           vectors = 0;
    int           errors  = 0;
    int           cyc     = 0;
    logic [W-1:0] acc_q [$];
    logic [W-1:0] got_q [$];
    bit           eof_q [$];
    int           xc_q  [$];
    logic [W-1:0] hold_data;
    bit           hold_pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: entered at the falling edge with inputs set, samples just before the rising edge.
    task automatic tick(output bit acc, output bit xfer);
        #3;
        acc  = in_valid && in_ready;
        xfer = out_valid && out_ready;
        if (hold_pend && !reset) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(hold_data));
        end
        hold_pend = out_valid && !out_ready && !reset;
        hold_data = out_data;
        if (acc) acc_q.push_back(in_data);
        if (xfer) begin
            got_q.push_back(out_data);
            xc_q.push_back(cyc);
`ifdef UNPOOL_EOF_EN
            eof_q.push_back(out_eof);
`else
            eof_q.push_back(1'b0);
`endif
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_log();
        acc_q.delete();
        got_q.delete();
        eof_q.delete();
        xc_q.delete();
        cyc = 0;
    endtask

    task automatic do_reset();
        bit a, x;
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        out_ready = 1'b0;
        #1;
        chk("in_ready_during_reset", 32'(in_ready), 32'd0);
        tick(a, x);
        in_valid = 1'b0;
        tick(a, x);
        reset = 1'b0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        clear_log();
    endtask

    // Reference: output k of the stream belongs to input row k/(4*IW), column ((k mod 2*IW)/2).
    function automatic logic [W-1:0] ref_out(input int k);
        int row;
        int col;
        row = k / (4 * IW);
        col = (k % (2 * IW)) / 2;
        return acc_q[row * IW + col];
    endfunction

    function automatic bit ref_eof(input int k);
        return ((k + 1) % (4 * IW * IH)) == 0;
    endfunction

    vec_t         tbl [3];
    logic [W-1:0] exp34 [8];

    initial begin
        bit a, x;
        int idx;
        int first_acc;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        tbl[0].n_in = 4;   tbl[0].vin = {16'd1, 16'd2, 16'd3, 16'd4};
        tbl[0].toggle = 1'b0; tbl[0].n_out = 16;
        tbl[0].vout = {16'd1, 16'd1, 16'd2, 16'd2, 16'd1, 16'd1, 16'd2, 16'd2,
                       16'd3, 16'd3, 16'd4, 16'd4, 16'd3, 16'd3, 16'd4, 16'd4};
        tbl[1].n_in = 2;   tbl[1].vin = {16'hFFFB, 16'h7FFF, 16'h0, 16'h0};
        tbl[1].toggle = 1'b0; tbl[1].n_out = 8;
        tbl[1].vout = {16'hFFFB, 16'hFFFB, 16'h7FFF, 16'h7FFF, 16'hFFFB, 16'hFFFB, 16'h7FFF, 16'h7FFF,
                       16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        tbl[2].n_in = 2;   tbl[2].vin = {16'd1, 16'd2, 16'd0, 16'd0};
        tbl[2].toggle = 1'b1; tbl[2].n_out = 8;
        tbl[2].vout = {16'd1, 16'd1, 16'd2, 16'd2, 16'd1, 16'd1, 16'd2, 16'd2,
                       16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        exp34 = '{16'd8, 16'd8, 16'd9, 16'd9, 16'd8, 16'd8, 16'd9, 16'd9};

        @(negedge clk);

        for (int r = 0; r < 3; r++) begin
            do_reset();
            idx = 0;
            first_acc = -1;
            for (int c = 0; c < 80 && got_q.size() < tbl[r].n_out; c++) begin
                in_valid  = (idx < tbl[r].n_in);
                in_data   = (idx < tbl[r].n_in) ? tbl[r].vin[idx] : 16'h0;
                out_ready = tbl[r].toggle ? (c % 2 == 0) : 1'b1;
                if (tbl[r].toggle && idx == tbl[r].n_in && got_q.size() < tbl[r].n_out - 2) begin
                    #1;
                    chk("in_ready_replay", 32'(in_ready), 32'd0);
                end
                tick(a, x);
                if (a) begin
                    if (first_acc < 0) first_acc = cyc - 1;
                    idx++;
                end
            end
            chk("vec_out_count", 32'(got_q.size()), 32'(tbl[r].n_out));
            for (int k = 0; k < got_q.size() && k < tbl[r].n_out; k++) begin
                chk("vec_out_data", 32'(got_q[k]), 32'(tbl[r].vout[k]));
                if (!tbl[r].toggle)
                    chk("vec_out_cycle", 32'(xc_q[k]), 32'(first_acc + 1 + k));
`ifdef UNPOOL_EOF_EN
                chk("vec_eof", 32'(eof_q[k]), 32'((tbl[r].n_in == 4) && (k == 15)));
`endif
            end
            $display("vector %0d: %0d inputs accepted, %0d outputs collected", r, acc_q.size(), got_q.size());
        end

        // Reset while the first copy of 7 is held: 7 must never appear afterwards.
        do_reset();
        in_valid = 1'b1; in_data = 16'd7; out_ready = 1'b0;
        tick(a, x);
        chk("accept_7", 32'(a), 32'd1);
        reset = 1'b1; in_valid = 1'b0;
        tick(a, x);
        reset = 1'b0;
        #1;
        chk("midrow_reset_out_valid", 32'(out_valid), 32'd0);
        clear_log();
        idx = 0;
        for (int c = 0; c < 40 && got_q.size() < 8; c++) begin
            in_valid  = (idx < 2);
            in_data   = (idx == 0) ? 16'd8 : 16'd9;
            out_ready = 1'b1;
            tick(a, x);
            if (a) idx++;
        end
        chk("midrow_reset_count", 32'(got_q.size()), 32'd8);
        for (int k = 0; k < got_q.size() && k < 8; k++)
            chk("midrow_reset_data", 32'(got_q[k]), 32'(exp34[k]));
        $display("reset sequence: %0d outputs collected after mid-row reset", got_q.size());

        // Randomized traffic with back-pressure and input stalls against the reference.
        do_reset();
        for (int c = 0; c < 3000 && !(acc_q.size() == 40 && got_q.size() == 160); c++) begin
            in_valid  = (acc_q.size() < 40) && ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick(a, x);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick(a, x);
        chk("rand_in_count", 32'(acc_q.size()), 32'd40);
        chk("rand_out_count", 32'(got_q.size()), 32'd160);
        chk("rand_drained", 32'(out_valid), 32'd0);
        for (int k = 0; k < got_q.size() && k < 4 * acc_q.size(); k++) begin
            chk("rand_data", 32'(got_q[k]), 32'(ref_out(k)));
`ifdef UNPOOL_EOF_EN
            chk("rand_eof", 32'(eof_q[k]), 32'(ref_eof(k)));
`endif
        end
        $display("random run: %0d inputs, %0d outputs in %0d cycles", acc_q.size(), got_q.size(), cyc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/unpool2x2.md
UNPOOL2X2 -- requirements
Module: unpool2x2

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16: signed data word width.
REQ-002 SHALL have parameter IN_WIDTH, default 14: pooled words per input row; legal range 2..1024.
REQ-003 SHALL have parameter IN_HEIGHT, default 14: input rows per frame; used only when UNPOOL_EOF_EN is defined.
REQ-004 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  WORD_SIZE: signed pooled word, raster order.
REQ-007 SHALL have port in_valid  input  1: in_data valid.
REQ-008 SHALL have port in_ready  output  1: block accepts in_data this cycle.
REQ-009 SHALL have port out_data  output  WORD_SIZE: signed upsampled word, raster order.
REQ-010 SHALL have port out_valid  output  1: out_data valid.
REQ-011 SHALL have port out_ready  input  1: downstream accepts out_data this cycle.

Function
REQ-012 SHALL map each input row of IN_WIDTH words to two identical output rows of 2*IN_WIDTH words, each input word emitted twice consecutively (2x2 nearest-neighbour replication); values pass unmodified, no arithmetic, sign preserved.
REQ-013 SHALL hold one output register (out_data, out_valid), a copy flag dup, a column counter col (0..IN_WIDTH-1), a row buffer buf[IN_WIDTH] and a two-state FSM {FILL, REPLAY}; the state names the source of the next load.
REQ-014 SHALL define transfer = out_valid && out_ready, and slot_free = !out_valid || (out_ready && dup==0).
REQ-015 SHALL drive in_ready = (state==FILL) && slot_free, combinationally; in_ready is 0 in REPLAY.
REQ-016 FILL, in_valid && in_ready: out_data<=in_data, buf[col]<=in_data, out_valid<=1, dup<=1.
REQ-017 REPLAY, slot_free: out_data<=buf[col], out_valid<=1, dup<=1.
REQ-018 On any load, col SHALL increment; at col==IN_WIDTH-1 it SHALL wrap to 0 and the state SHALL toggle (FILL->REPLAY, REPLAY->FILL).
REQ-019 Transfer with dup==1 SHALL clear dup and keep out_valid=1 and out_data unchanged (second copy).
REQ-020 Transfer with dup==0 and no load in the same cycle SHALL clear out_valid.
REQ-021 While out_valid && !out_ready, out_data and out_valid SHALL hold.
REQ-022 Latency: out_valid rises the cycle after input acceptance; with out_ready held high and in_valid supplied, throughput SHALL be one output word per cycle, including across row boundaries (no bubbles).
REQ-023 Input stalls (in_valid low in FILL) SHALL produce out_valid low once the held word drains; no word is lost or duplicated beyond two copies.

Reset
REQ-024 When reset is high at a clock edge: state<=FILL, col<=0, dup<=0, out_valid<=0, out_data<=0; out_eof<=0 and row counter<=0 if present.
REQ-025 buf SHALL NOT be reset; its contents are never emitted before being rewritten in the current row.
REQ-026 Reset mid-row or mid-REPLAY SHALL discard the partial row; the first input after reset is column 0 of a new row.
REQ-027 in_ready SHALL be 0 while reset is high.

Configuration
REQ-028 Macro UNPOOL_EOF_EN, when defined, SHALL add port out_eof  output  1 and a row counter (0..IN_HEIGHT-1) incremented on each REPLAY->FILL wrap, wrapping to 0 after IN_HEIGHT-1.
REQ-029 With UNPOOL_EOF_EN, out_eof SHALL be 1 exactly while the held word is the second copy of column IN_WIDTH-1 of the REPLAY row of input row IN_HEIGHT-1, and SHALL follow out_data hold rules.
REQ-030 Without UNPOOL_EOF_EN, out_eof and the row counter SHALL not exist; the stream is frameless and IN_HEIGHT is unused.

Verification (IN_WIDTH=2, WORD_SIZE=16)
REQ-031 Inputs 1,2,3,4 back-to-back, out_ready=1 -> outputs 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4 on 16 consecutive cycles, first one the cycle after accepting 1.
REQ-032 Input 0xFFFB (-5), 0x7FFF -> outputs 0xFFFB,0xFFFB,0x7FFF,0x7FFF,0xFFFB,0xFFFB,0x7FFF,0x7FFF bit-exact.
REQ-033 Inputs 1,2 with out_ready toggling 1,0,1,0... -> same sequence 1,1,2,2,1,1,2,2, out_data stable during every out_ready=0 cycle, in_ready=0 throughout REPLAY.
REQ-034 Accept 7, reset at the first-copy cycle, then inputs 8,9 -> no 7 emitted after reset; outputs 8,8,9,9,8,8,9,9.
REQ-035 UNPOOL_EOF_EN, IN_HEIGHT=2, inputs 1..4 -> out_eof=1 only on output 16 (value 4); repeat frame gives out_eof only on output 32.
